// File: rtl/regfile_wb_arb.sv
// Register file writeback arbiter: round-robin selection among N_REQ writeback
// sources, one registered write per cycle, x0 writes dropped, read-port bypass.
package etcpu_pckg;
    localparam int REG_W = 5;
    localparam int REG_S = 32;
endpackage

module regfile_wb_arb #(
    parameter int REG_W = etcpu_pckg::REG_W,
    parameter int REG_S = etcpu_pckg::REG_S,
    parameter int N_REQ = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_vld,
    output logic [N_REQ-1:0]                  req_rdy,
    input  logic [N_REQ-1:0][REG_W-1:0]       req_wa,
    input  logic [N_REQ-1:0][REG_S-1:0]       req_wd,
    output logic                              we,
    output logic [REG_W-1:0]                  wa,
    output logic [REG_S-1:0]                  wd,
    input  logic [REG_W-1:0]                  rs1,
    input  logic [REG_W-1:0]                  rs2,
    output logic                              byp1_hit,
    output logic [REG_S-1:0]                  byp1_dat,
    output logic                              byp2_hit,
    output logic [REG_S-1:0]                  byp2_dat
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: requester i transfers in any cycle where req_vld[i] && req_rdy[i].
    // req_rdy is a pure function of req_vld and last; the port always accepts.
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] win;
    logic             xfer;
    logic [REG_W-1:0] win_wa;
    logic [REG_S-1:0] win_wd;
    int               idx;

    // Scan starting one past the previous winner so every requester rotates to top.
    always_comb begin
        req_rdy = '0;
        win     = '0;
        xfer    = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!xfer && req_vld[idx]) begin
                xfer = 1'b1;
                win  = IDX_W'(idx);
            end
        end
        if (xfer) begin
            req_rdy[win] = 1'b1;
        end
    end

    assign win_wa = req_wa[win];
    assign win_wd = req_wd[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we   <= 1'b0;
            wa   <= '0;
            wd   <= '0;
            last <= IDX_W'(N_REQ - 1);
        end else begin
            // x0 writes still consume a grant but never reach the port.
            we <= xfer && (win_wa != '0);
            if (xfer) begin
                wa   <= win_wa;
                wd   <= win_wd;
                last <= win;
            end
        end
    end

    // we is never set for x0, so a zero read address cannot hit.
    assign byp1_hit = we && (wa == rs1);
    assign byp2_hit = we && (wa == rs2);
    assign byp1_dat = wd;
    assign byp2_dat = wd;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with a small register file model on the write port.
module tb_regfile_wb_arb;

    localparam int REG_W = 5;
    localparam int REG_S = 32;
    localparam int N_REQ = 2;

    logic                        clk;
    logic                        rst_n;
    logic [N_REQ-1:0]            req_vld;
    logic [N_REQ-1:0]            req_rdy;
    logic [N_REQ-1:0][REG_W-1:0] req_wa;
    logic [N_REQ-1:0][REG_S-1:0] req_wd;
    logic                        we;
    logic [REG_W-1:0]            wa;
    logic [REG_S-1:0]            wd;
    logic [REG_W-1:0]            rs1;
    logic [REG_W-1:0]            rs2;
    logic                        byp1_hit;
    logic [REG_S-1:0]            byp1_dat;
    logic                        byp2_hit;
    logic [REG_S-1:0]            byp2_dat;

    int checks;
    int failures;

    logic [REG_S-1:0] rf [2**REG_W];

    regfile_wb_arb #(.REG_W(REG_W), .REG_S(REG_S), .N_REQ(N_REQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wa(req_wa), .req_wd(req_wd),
        .we(we), .wa(wa), .wd(wd),
        .rs1(rs1), .rs2(rs2),
        .byp1_hit(byp1_hit), .byp1_dat(byp1_dat),
        .byp2_hit(byp2_hit), .byp2_dat(byp2_dat)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file fed by the arbiter's write port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_W; i++) rf[i] <= '0;
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] vld, input logic [4:0] wa0, input logic [31:0] wd0,
                           input logic [4:0] wa1, input logic [31:0] wd1);
        req_vld   = vld;
        req_wa[0] = wa0;
        req_wd[0] = wd0;
        req_wa[1] = wa1;
        req_wd[1] = wd1;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_vld  = '0;
        req_wa   = '0;
        req_wd   = '0;
        rs1      = '0;
        rs2      = '0;

        // reset state
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wa", 32'(wa), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_byp1", 32'(byp1_hit), 32'd0);
        chk("rst_byp2", 32'(byp2_hit), 32'd0);
        rst_n = 1'b1;

        // round robin, both valid for four cycles
        set_req(2'b11, 5'd1, 32'h100, 5'd2, 32'h200);
        chk("rr_rdy0", 32'(req_rdy), 32'h1);
        tick();
        chk("rr_we0", 32'(we), 32'd1);
        chk("rr_wa0", 32'(wa), 32'd1);
        chk("rr_wd0", wd, 32'h100);
        chk("rr_rdy1", 32'(req_rdy), 32'h2);
        tick();
        chk("rr_wa1", 32'(wa), 32'd2);
        chk("rr_wd1", wd, 32'h200);
        chk("rr_rdy2", 32'(req_rdy), 32'h1);
        tick();
        chk("rr_wa2", 32'(wa), 32'd1);
        chk("rr_rdy3", 32'(req_rdy), 32'h2);
        tick();
        chk("rr_wa3", 32'(wa), 32'd2);
        chk("rr_wd3", wd, 32'h200);
        chk("rr_we3", 32'(we), 32'd1);

        // asynchronous reset with a staged write, then requester 0 wins first
        set_req(2'b00, 5'd1, 32'h100, 5'd2, 32'h200);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_wa", 32'(wa), 32'd0);
        chk("arst_wd", wd, 32'd0);
        rst_n = 1'b1;
        set_req(2'b11, 5'd1, 32'h100, 5'd2, 32'h200);
        chk("arst_rdy", 32'(req_rdy), 32'h1);
        tick();
        chk("arst_wa1", 32'(wa), 32'd1);

        // single requester 1, three consecutive grants to r5
        set_req(2'b10, 5'd0, 32'h0, 5'd5, 32'hA);
        chk("one_rdy0", 32'(req_rdy), 32'h2);
        tick();
        chk("one_we0", 32'(we), 32'd1);
        chk("one_wa0", 32'(wa), 32'd5);
        chk("one_wd0", wd, 32'hA);
        set_req(2'b10, 5'd0, 32'h0, 5'd5, 32'hB);
        chk("one_rdy1", 32'(req_rdy), 32'h2);
        tick();
        chk("one_wd1", wd, 32'hB);
        set_req(2'b10, 5'd0, 32'h0, 5'd5, 32'hC);
        chk("one_rdy2", 32'(req_rdy), 32'h2);
        tick();
        chk("one_we2", 32'(we), 32'd1);
        chk("one_wd2", wd, 32'hC);
        set_req(2'b00, 5'd0, 32'h0, 5'd5, 32'hC);
        tick();
        chk("one_idle_we", 32'(we), 32'd0);
        chk("one_rf5", rf[5], 32'hC);

        // x0 write: accepted, advances priority, never written
        set_req(2'b01, 5'd0, 32'hDEAD, 5'd6, 32'h66);
        chk("x0_rdy", 32'(req_rdy), 32'h1);
        tick();
        chk("x0_we", 32'(we), 32'd0);
        chk("x0_last", 32'(dut.last), 32'd0);
        set_req(2'b11, 5'd1, 32'h1, 5'd6, 32'h66);
        chk("x0_next_rdy", 32'(req_rdy), 32'h2);
        tick();
        chk("x0_next_we", 32'(we), 32'd1);
        chk("x0_next_wa", 32'(wa), 32'd6);
        set_req(2'b00, 5'd1, 32'h1, 5'd6, 32'h66);
        tick();
        chk("x0_rf0", rf[0], 32'd0);

        // bypass hit on rs1, miss on rs2
        set_req(2'b01, 5'd7, 32'h1234, 5'd0, 32'h0);
        chk("byp_rdy", 32'(req_rdy), 32'h1);
        tick();
        set_req(2'b00, 5'd7, 32'h1234, 5'd0, 32'h0);
        rs1 = 5'd7;
        rs2 = 5'd3;
        #1;
        chk("byp1_hit", 32'(byp1_hit), 32'd1);
        chk("byp1_dat", byp1_dat, 32'h1234);
        chk("byp2_miss", 32'(byp2_hit), 32'd0);
        chk("byp2_dat", byp2_dat, 32'h1234);
        tick();
        chk("byp1_late", 32'(byp1_hit), 32'd0);
        chk("byp2_late", 32'(byp2_hit), 32'd0);
        chk("byp_rf7", rf[7], 32'h1234);

        // same register written back to back commits in acceptance order
        rs1 = 5'd4;
        rs2 = 5'd0;
        set_req(2'b01, 5'd4, 32'h11, 5'd0, 32'h0);
        chk("ord_rdy0", 32'(req_rdy), 32'h1);
        tick();
        set_req(2'b10, 5'd0, 32'h0, 5'd4, 32'h22);
        chk("ord_rdy1", 32'(req_rdy), 32'h2);
        chk("ord_hit0", 32'(byp1_hit), 32'd1);
        chk("ord_dat0", byp1_dat, 32'h11);
        chk("ord_rs2_zero", 32'(byp2_hit), 32'd0);
        tick();
        set_req(2'b00, 5'd0, 32'h0, 5'd4, 32'h22);
        chk("ord_hit1", 32'(byp1_hit), 32'd1);
        chk("ord_dat1", byp1_dat, 32'h22);
        tick();
        chk("ord_rf4", rf[4], 32'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
